// File: rtl/y_dm_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : y_dm_responder
//  Description : Multi-cycle data-memory responder. Accepts one word-aligned
//                read or write request at a time. It holds the request for
//                LATENCY wait states, then performs the access on an
//                internal word array. Completion is signalled by a
//                one-cycle ack, with registered read data and an error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module y_dm_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    localparam logic [3:0] c_wait_init = 4'(LATENCY - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic          r_write;
    logic          r_misalign;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH];

    logic          w_req;
    logic          w_access;
    logic          w_unused_addr;

    assign w_req    = MemRead | MemWrite;
    assign w_access = (r_state == c_st_wait) && (r_cnt == 4'd0);

    // Address bits above the array index wrap and are deliberately ignored.
    assign w_unused_addr = &{1'b0, addr[31:AW+2]};

    // State register; reset drops any pending access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: requests are only sampled in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (w_req) w_next_state = c_st_wait;
            c_st_wait: if (r_cnt == 4'd0) w_next_state = c_st_resp;
            c_st_resp: w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    // Request capture and wait-state counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= 4'd0;
            r_idx      <= '0;
            r_wdata    <= 32'h0;
            r_write    <= 1'b0;
            r_misalign <= 1'b0;
        end else if (r_state == c_st_idle && w_req) begin
            r_cnt      <= c_wait_init;
            r_idx      <= addr[AW+1:2];
            r_wdata    <= wdata;
            r_write    <= MemWrite;   // simultaneous read+write acts as a write
            r_misalign <= (addr[1:0] != 2'b00);
        end else if (r_state == c_st_wait && r_cnt != 4'd0) begin
            r_cnt      <= r_cnt - 4'd1;
        end
    end

    // Read data and error flag update at the WAIT->RESP edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else if (w_access) begin
            if (r_misalign) begin
                r_err <= 1'b1;
            end else begin
                r_err <= 1'b0;
                if (!r_write) begin
                    r_rdata <= r_mem[r_idx];
                end
            end
        end
    end

    // Word array write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_access && r_write && !r_misalign) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        ack   = (r_state == c_st_resp);
        busy  = (r_state != c_st_idle);
        err   = r_err && (r_state == c_st_resp);
        rdata = r_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_y_dm_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_y_dm_responder
//  Description : Directed self-checking bench for y_dm_responder. A LATENCY=2
//                instance covers read/write, misalignment, wrap, dual request
//                and reset behaviour; a LATENCY=1 instance covers a request
//                held across ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_y_dm_responder;

    logic        clk;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;

    logic        rd2;
    logic        wr2;
    logic [31:0] addr2;
    logic [31:0] wdata2;
    logic [31:0] rdata2;
    logic        ack2;
    logic        err2;
    logic        busy2;

    int n_checks;
    int n_errors;

    y_dm_responder #(.DEPTH(256), .LATENCY(2)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (rd),
        .MemWrite (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ack      (ack),
        .err      (err),
        .busy     (busy)
    );

    y_dm_responder #(.DEPTH(256), .LATENCY(1)) u_dut_l1 (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (rd2),
        .MemWrite (wr2),
        .addr     (addr2),
        .wdata    (wdata2),
        .rdata    (rdata2),
        .ack      (ack2),
        .err      (err2),
        .busy     (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete request on the LATENCY=2 instance with its expected response.
    task automatic do_req(input string tag, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic exp_err, input logic [31:0] exp_rdata);
        int edges;
        edges = 0;
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d;
        @(posedge clk); #1;
        check({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
        check({tag, "_ack_e0"},  {31'd0, ack},  32'd0);
        while (ack !== 1'b1 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_latency"}, edges, 32'd2);
        rd = 1'b0; wr = 1'b0;
        check({tag, "_err"},   {31'd0, err}, {31'd0, exp_err});
        check({tag, "_rdata"}, rdata, exp_rdata);
        @(posedge clk); #1;
        check({tag, "_idle_ack"},  {31'd0, ack},  32'd0);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int first_ack;
        int second_ack;
        logic prev_ack;
        n_checks = 0;
        n_errors = 0;
        rd = 0; wr = 0; addr = 0; wdata = 0;
        rd2 = 0; wr2 = 0; addr2 = 0; wdata2 = 0;
        reset = 1'b1;
        #1;
        check("rst_ack",   {31'd0, ack},  32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_err",   {31'd0, err},  32'd0);
        check("rst_rdata", rdata,         32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic write then read
        do_req("wr10",   1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        do_req("rd10",   1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF);
        // Misaligned read keeps rdata; misaligned write must not touch array
        do_req("wr10b",  1'b0, 1'b1, 32'h10, 32'h12345678, 1'b0, 32'hDEADBEEF);
        do_req("rd13",   1'b1, 1'b0, 32'h13, 32'h0,        1'b1, 32'hDEADBEEF);
        do_req("wr12",   1'b0, 1'b1, 32'h12, 32'h99999999, 1'b1, 32'hDEADBEEF);
        do_req("rd10b",  1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'h12345678);
        // Address wrap modulo 1 KiB
        do_req("wr408",  1'b0, 1'b1, 32'h408, 32'hA5A5A5A5, 1'b0, 32'h12345678);
        do_req("rd008",  1'b1, 1'b0, 32'h008, 32'h0,        1'b0, 32'hA5A5A5A5);
        // Read and write together act as a write
        do_req("both20", 1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, 32'hA5A5A5A5);
        do_req("rd20",   1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 32'hCAFEF00D);

        // Reset in the first WAIT cycle drops the pending write
        do_req("wr30",   1'b0, 1'b1, 32'h30, 32'h22222222, 1'b0, 32'hCAFEF00D);
        @(negedge clk);
        wr = 1'b1; addr = 32'h30; wdata = 32'h11111111;
        @(posedge clk); #1;
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_busy",  {31'd0, busy}, 32'd0);
        check("mid_ack",   {31'd0, ack},  32'd0);
        check("mid_rdata", rdata,         32'h0);
        wr = 1'b0;
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("mid_no_ack", {31'd0, ack}, 32'd0);
        end
        do_req("rd30",   1'b1, 1'b0, 32'h30, 32'h0,        1'b0, 32'h22222222);

        // Reset during RESP clears ack and the registered read data
        @(negedge clk);
        rd = 1'b1; addr = 32'h20;
        repeat (3) @(posedge clk);
        #1;
        check("resp_ack",   {31'd0, ack}, 32'd1);
        check("resp_rdata", rdata,        32'hCAFEF00D);
        rd = 1'b0;
        reset = 1'b1;
        #1;
        check("resp_rst_ack",   {31'd0, ack}, 32'd0);
        check("resp_rst_rdata", rdata,        32'h0);
        #2 reset = 1'b0;

        // LATENCY=1: request held across ack is serviced every 3 cycles
        first_ack  = -1;
        second_ack = -1;
        prev_ack   = 1'b0;
        @(negedge clk);
        rd2 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            check("l1_no_double_ack", {31'd0, prev_ack & ack2}, 32'd0);
            if (ack2 === 1'b1) begin
                if (first_ack < 0) first_ack = c;
                else if (second_ack < 0) second_ack = c;
            end
            prev_ack = ack2;
        end
        rd2 = 1'b0;
        check("l1_first_ack",  first_ack, 32'd1);
        check("l1_ack_period", second_ack - first_ack, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/y_dm_responder.md
# y_dm_responder

Multi-cycle data-memory responder: the target side of the `MemRead`/`MemWrite` data-memory port that the datapath's memory stage drives. It accepts one word-aligned read or write request at a time and holds it for a programmable number of wait states. It then performs the access on an internal word array and returns a one-cycle `ack` with read data and an error flag. It replaces the zero-wait memory when the multi-cycle datapath is exercised against slow memory.

## Interface
- `DEPTH`, 256 — number of 32-bit words; power of two, at least 2; index width `AW` = log2(`DEPTH`).
- `LATENCY`, 2 — wait-state cycles between request capture and access; legal range 1..15.

- `clk` input 1 — single clock; all state changes on the rising edge.
- `reset` input 1 — asynchronous, active-high reset.
- `MemRead` input 1 — read request; level, held by the initiator until `ack`.
- `MemWrite` input 1 — write request; level, held by the initiator until `ack`.
- `addr` input 32 — byte address; stable while a request is held.
- `wdata` input 32 — write data; stable while `MemWrite` is held.
- `rdata` output 32 — registered read data; valid while `ack` is high, and held until the next successful read.
- `ack` output 1 — one-cycle completion pulse.
- `err` output 1 — high with `ack` when the completed request was misaligned; otherwise 0.
- `busy` output 1 — high whenever the state is not IDLE.

## Operation
- States: IDLE, WAIT, RESP. Wait counter is 4 bits.
- IDLE: if `MemRead | MemWrite` is high at an edge, capture `addr`, `wdata`, the op (write = `MemWrite`) and misalign = (`addr[1:0]` != 0). Then go to WAIT with counter = `LATENCY`-1. Otherwise stay in IDLE.
- WAIT: if counter == 0, go to RESP and perform the access at this edge. Otherwise decrement the counter. Requests are not sampled in WAIT; input changes are ignored.
- Access, done at the WAIT→RESP edge:
  - If misaligned: no array access, `rdata` unchanged, `err` set.
  - Aligned write: `array[addr[AW+1:2]] <= wdata`.
  - Aligned read: `rdata <= array[addr[AW+1:2]]`.
  - `err` cleared for any aligned access.
- RESP: `ack` = 1 for exactly this cycle. Go to IDLE unconditionally; requests are not sampled in RESP.
- Both `MemRead` and `MemWrite` high: the request is treated as a write; `rdata` is unchanged; no error.
- Address width: only `addr[AW+1:2]` selects a word. Upper bits are ignored, so addresses wrap modulo 4·`DEPTH` bytes.
- Array contents have no reset. Only control state, `rdata` and `err` reset.
- Handshake rules for the initiator:
  - Deassert the request, or present a new one, in the cycle after `ack`.
  - A request still high in IDLE is serviced again as a new request.

## Timing
- Reset (async, immediate):
  - State goes to IDLE; counter = 0.
  - `ack` = 0, `err` = 0, `busy` = 0, `rdata` = 32'h0.
  - A pending access is dropped: a write in WAIT does not commit.
- Request high before edge E0 (IDLE):
  - `busy` is high from E0.
  - The access happens at edge E0+`LATENCY`.
  - `ack` is high in the cycle after E0+`LATENCY`.
  - Return to IDLE at E0+`LATENCY`+1.
- Turnaround: a request held continuously is recaptured at E0+`LATENCY`+2. Minimum period is `LATENCY`+2 cycles per request.
- `ack`, `busy` and `err` are decoded from registered state only; there is no combinational path from the inputs.
- Reset asserted during RESP: `ack` falls immediately. A read already registered in `rdata` is cleared to 0.

## Test plan
- `LATENCY`=2, `DEPTH`=256:
  - Write 32'hDEADBEEF to addr 0x10 → `busy` rises at E0, `ack` is high one cycle after E0+2, `err`=0.
  - Then read 0x10 → `rdata`=32'hDEADBEEF with `ack`.
- Read at addr 0x13 (misaligned) after writing 0x12345678 at 0x10 → `ack` arrives with `err`=1 and `rdata` keeps its previous value. A following aligned read of 0x10 returns 0x12345678 with `err`=0.
- Wrap-around: write 32'hA5A5A5A5 to 0x408 (`DEPTH`=256) → a read of 0x008 returns 32'hA5A5A5A5.
- `MemRead` and `MemWrite` both high with `wdata`=0xCAFEF00D at 0x20 → acts as a write, `rdata` unchanged. A later read of 0x20 returns 0xCAFEF00D.
- Reset mid-WAIT: start a write of 0x11111111 to 0x30 (after 0x30 was written with 0x22222222), then pulse `reset` in the first WAIT cycle. Required response:
  - `busy` and `ack` go to 0 immediately.
  - No `ack` appears.
  - A read of 0x30 afterwards returns 0x22222222.
- Held request with `LATENCY`=1: keep `MemRead` high across `ack` → the second `ack` comes exactly 3 cycles after the first, and `ack` never stays high for two consecutive cycles.
